// File: rtl/hazard_mem_controller_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states and memory-port
// select values.
package hazard_mem_controller_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    localparam logic MEM_SEL_FETCH = 1'b0;
    localparam logic MEM_SEL_DATA  = 1'b1;

endpackage

// File: rtl/hazard_mem_controller_load_use.sv
// Load-use hazard detector: the load in EX writes a register that the
// instruction in ID reads. x0 never creates a hazard.
module load_use_detect (
    input  logic       ID_EX_CTRL_memread,
    input  logic [4:0] ID_EX_rd,
    input  logic [4:0] IF_ID_rs1,
    input  logic [4:0] IF_ID_rs2,
    output logic       load_use
);

    assign load_use = ID_EX_CTRL_memread && (ID_EX_rd != 5'd0) &&
                      ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));

endmodule

// File: rtl/hazard_mem_controller.sv
// Pipeline sequencer for a single-ported unified memory: arbitrates fetch
// against data access and drives all pipeline enable/stall/flush controls.
module hazard_mem_controller
    import hazard_mem_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_CTRL_memread,
    input  logic             EX_MEM_CTRL_memread,
    input  logic             EX_MEM_CTRL_memwrite,
    input  logic             EX_branch_taken,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_sel,
    output logic             mem_we,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             pipe_en,
    output logic [CNT_W-1:0] stall_count
);

    state_t           state_q, state_d;
    logic             dataDone_q, dataDone_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             dataPend;
    logic             adv;
    logic             loadUse;

    load_use_detect u_load_use (
        .ID_EX_CTRL_memread (ID_EX_CTRL_memread),
        .ID_EX_rd           (ID_EX_rd),
        .IF_ID_rs1          (IF_ID_rs1),
        .IF_ID_rs2          (IF_ID_rs2),
        .load_use           (loadUse)
    );

    assign dataPend = (EX_MEM_CTRL_memread || EX_MEM_CTRL_memwrite) && !dataDone_q;
    assign adv      = (state_q == S_FETCH) && mem_ack;

    // Memory-port outputs decode from the state register only, so mem_ack
    // never reaches them combinationally.
    always_comb begin
        state_d    = state_q;
        dataDone_d = dataDone_q;
        mem_req    = 1'b0;
        mem_sel    = MEM_SEL_FETCH;
        mem_we     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                state_d = dataPend ? S_DATA : S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) state_d = S_IDLE;
            end
            S_DATA: begin
                mem_req = 1'b1;
                mem_sel = MEM_SEL_DATA;
                mem_we  = EX_MEM_CTRL_memwrite;
                if (mem_ack) begin
                    dataDone_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (adv) dataDone_d = 1'b0;
    end

    assign pipe_en      = adv;
    assign pc_write     = adv && (!loadUse || EX_branch_taken);
    assign IF_ID_write  = adv && (!loadUse || EX_branch_taken);
    assign IF_ID_flush  = adv && EX_branch_taken;
    assign ID_EX_bubble = adv && (loadUse || EX_branch_taken);

    always_comb begin
        count_d = count_q;
        if (!adv && !(&count_q)) count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign stall_count = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dataDone_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            dataDone_q <= dataDone_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_hazard_mem_controller.sv
// Self-checking bench: directed scenarios plus randomized segments, all
// compared against a transaction-level reference model of the sequencer.
module tb_hazard_mem_controller;

    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [4:0]    IF_ID_rs1 = '0, IF_ID_rs2 = '0, ID_EX_rd = '0;
    logic          ID_EX_CTRL_memread = 1'b0;
    logic          EX_MEM_CTRL_memread = 1'b0, EX_MEM_CTRL_memwrite = 1'b0;
    logic          EX_branch_taken = 1'b0, mem_ack = 1'b0;
    logic          mem_req, mem_sel, mem_we, pc_write, IF_ID_write;
    logic          IF_ID_flush, ID_EX_bubble, pipe_en;
    logic [CW-1:0] stall_count;

    int total = 0;
    int bad   = 0;

    // Reference model: which access is in flight (0 gap, 1 fetch, 2 data),
    // whether the current MEM-stage data access is finished, and the counter.
    int mAccess  = 0;
    bit mDone    = 1'b0;
    int mCount   = 0;
    bit mLastAdv = 1'b1;

    always #5 clk = ~clk;

    hazard_mem_controller #(.CNT_W(CW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .IF_ID_rs1            (IF_ID_rs1),
        .IF_ID_rs2            (IF_ID_rs2),
        .ID_EX_rd             (ID_EX_rd),
        .ID_EX_CTRL_memread   (ID_EX_CTRL_memread),
        .EX_MEM_CTRL_memread  (EX_MEM_CTRL_memread),
        .EX_MEM_CTRL_memwrite (EX_MEM_CTRL_memwrite),
        .EX_branch_taken      (EX_branch_taken),
        .mem_ack              (mem_ack),
        .mem_req              (mem_req),
        .mem_sel              (mem_sel),
        .mem_we               (mem_we),
        .pc_write             (pc_write),
        .IF_ID_write          (IF_ID_write),
        .IF_ID_flush          (IF_ID_flush),
        .ID_EX_bubble         (ID_EX_bubble),
        .pipe_en              (pipe_en),
        .stall_count          (stall_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] observedCtl();
        return {mem_req, mem_sel, mem_we, pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_en};
    endfunction

    function automatic logic [7:0] expectCtl();
        bit lu, adv, br;
        lu  = ID_EX_CTRL_memread && (ID_EX_rd != 0) && (ID_EX_rd == IF_ID_rs1 || ID_EX_rd == IF_ID_rs2);
        adv = (mAccess == 1) && mem_ack;
        br  = EX_branch_taken;
        return {mAccess != 0, mAccess == 2, (mAccess == 2) && EX_MEM_CTRL_memwrite,
                adv && (!lu || br), adv && (!lu || br), adv && br, adv && (lu || br), adv};
    endfunction

    task automatic modelAdvance();
        bit adv;
        adv = (mAccess == 1) && mem_ack;
        if (!adv) mCount = (mCount < MAXC) ? mCount + 1 : MAXC;
        case (mAccess)
            0: mAccess = ((EX_MEM_CTRL_memread || EX_MEM_CTRL_memwrite) && !mDone) ? 2 : 1;
            1: if (mem_ack) mAccess = 0;
            default: if (mem_ack) begin mDone = 1'b1; mAccess = 0; end
        endcase
        if (adv) mDone = 1'b0;
        mLastAdv = adv;
    endtask

    // One clock: compare mid-cycle, advance the model, land just after the edge.
    task automatic applyStimulus();
        @(negedge clk);
        checkOutput("ctl", {24'd0, observedCtl()}, {24'd0, expectCtl()});
        checkOutput("cnt", {{(32-CW){1'b0}}, stall_count}, mCount);
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_ctl", {24'd0, observedCtl()}, 32'd0);
        checkOutput("rst_cnt", {{(32-CW){1'b0}}, stall_count}, 32'd0);
        mAccess  = 0;
        mDone    = 1'b0;
        mCount   = 0;
        mLastAdv = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        doReset();

        // Idle/fetch alternation with immediate acks.
        mem_ack = 1'b1;
        repeat (6) applyStimulus();
        checkOutput("cnt_after6", {{(32-CW){1'b0}}, stall_count}, 32'd3);

        // Store with an ack delayed by three cycles, then the following fetch.
        EX_MEM_CTRL_memwrite = 1'b1;
        mem_ack = 1'b0;
        repeat (4) applyStimulus();
        mem_ack = 1'b1;
        repeat (3) applyStimulus();
        EX_MEM_CTRL_memwrite = 1'b0;

        // Load-use on rs2, then the same with rd=x0, then load-use plus branch.
        ID_EX_CTRL_memread = 1'b1;
        ID_EX_rd = 5'd5;
        IF_ID_rs2 = 5'd5;
        IF_ID_rs1 = 5'd7;
        repeat (2) applyStimulus();
        ID_EX_rd = 5'd0;
        IF_ID_rs2 = 5'd0;
        repeat (2) applyStimulus();
        ID_EX_rd = 5'd5;
        IF_ID_rs2 = 5'd5;
        EX_branch_taken = 1'b1;
        repeat (2) applyStimulus();
        EX_branch_taken = 1'b0;
        ID_EX_CTRL_memread = 1'b0;

        // Reset in the middle of a data access.
        EX_MEM_CTRL_memread = 1'b1;
        mem_ack = 1'b0;
        repeat (2) applyStimulus();
        checkOutput("pre_rst_req", {31'd0, mem_req}, 32'd1);
        doReset();
        mem_ack = 1'b1;
        applyStimulus();
        checkOutput("post_rst_sel", {31'd0, mem_sel}, 32'd1);
        repeat (3) applyStimulus();
        EX_MEM_CTRL_memread = 1'b0;

        // Counter saturation with the memory never acknowledging.
        doReset();
        mem_ack = 1'b0;
        repeat ((1 << CW) + 2) applyStimulus();
        checkOutput("cnt_sat", {{(32-CW){1'b0}}, stall_count}, MAXC);

        // Randomized segments, each starting from reset.
        for (int seg = 0; seg < 30; seg++) begin
            doReset();
            for (int cyc = 0; cyc < 14; cyc++) begin
                int op;
                IF_ID_rs1          = 5'($urandom_range(0, 3));
                IF_ID_rs2          = 5'($urandom_range(0, 3));
                ID_EX_rd           = 5'($urandom_range(0, 3));
                ID_EX_CTRL_memread = 1'($urandom_range(0, 1));
                EX_branch_taken    = ($urandom_range(0, 3) == 0);
                mem_ack            = 1'($urandom_range(0, 1));
                if (mLastAdv) begin
                    op = $urandom_range(0, 3);
                    EX_MEM_CTRL_memread  = (op == 2);
                    EX_MEM_CTRL_memwrite = (op == 3);
                end
                applyStimulus();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
